// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory and decode-side signals of the fetch queue
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic [31:0] iad;
  logic ireq;
  logic [31:0] idt;
  logic acki_n;
  logic redirect;
  logic [31:0] redirect_pc;
  logic id_ready;
  logic valid_out;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic [$clog2(DEPTH):0] count;
  modport master (
    input idt, acki_n, redirect, redirect_pc, id_ready,
    output iad, ireq, valid_out, ir_out, pc_out, count
  );
  modport slave (
    output idt, acki_n, redirect, redirect_pc, id_ready,
    input iad, ireq, valid_out, ir_out, pc_out, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC-tagged instruction prefetch queue feeding the IF-ID register
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] r_fetch_pc;
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [31:0] r_pc [DEPTH];
  logic [31:0] r_ir [DEPTH];
  logic w_ireq, w_valid, w_enq, w_deq;
  assign w_ireq = (r_count < CW'(DEPTH)) && !bus.redirect;
  assign w_valid = (r_count != '0) && !bus.redirect;
  assign w_enq = w_ireq && !bus.acki_n;
  assign w_deq = w_valid && bus.id_ready;
  assign bus.ireq = w_ireq;
  assign bus.valid_out = w_valid;
  assign bus.iad = r_fetch_pc;
  assign bus.ir_out = w_valid ? r_ir[r_head] : NOP;
  assign bus.pc_out = w_valid ? r_pc[r_head] : 32'h0;
  assign bus.count = r_count;
  // capture each accepted word together with the address it was fetched from
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc[r_tail] <= r_fetch_pc;
      r_ir[r_tail] <= bus.idt;
    end
  end
  // pointers, occupancy and fetch address; a redirect flushes and wins over everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= bus.redirect_pc & ~32'h3;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_deq) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed table, corner sequences and randomized model check of fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0001_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic ack, idr, red;
    logic [31:0] rpc, idt, iad;
    logic ireq, vld;
    logic [31:0] pc, ir;
    int cnt;
  } vec_t;
  vec_t tbl[$];
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] iad, input logic ireq, input logic vld,
                         input logic [31:0] pc, input logic [31:0] ir, input int cnt);
    chk({tag, ".iad"}, bus.iad, iad);
    chk({tag, ".ireq"}, 32'(bus.ireq), 32'(ireq));
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(vld));
    chk({tag, ".pc_out"}, bus.pc_out, pc);
    chk({tag, ".ir_out"}, bus.ir_out, ir);
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
  endtask
  task automatic add(input logic ack, idr, red, input logic [31:0] rpc, idt, iad, input logic ireq, vld,
                     input logic [31:0] pc, ir, input int cnt);
    vec_t v;
    v = '{ack, idr, red, rpc, idt, iad, ireq, vld, pc, ir, cnt};
    tbl.push_back(v);
  endtask
  task automatic drive(input logic ack, idr, red, input logic [31:0] rpc, idt);
    bus.acki_n = ack;
    bus.id_ready = idr;
    bus.redirect = red;
    bus.redirect_pc = rpc;
    bus.idt = idt;
  endtask
  initial begin
    logic m_ireq, m_vld;
    drive(I, O, O, 32'h0, 32'h0);
    // reset state
    @(negedge clk);
    @(negedge clk);
    #1 chk_all("reset", RPC, I, O, 32'h0, NOP, 0);
    reset = 1'b0;
    @(negedge clk);
    // directed table: streaming, fill to full, single dequeue, wait states, redirect
    add(O, I, O, 32'h0, 32'hA0A0_0001, 32'h1_0000, I, O, 32'h0,     NOP,            0);
    add(O, I, O, 32'h0, 32'hA0A0_0002, 32'h1_0004, I, I, 32'h1_0000, 32'hA0A0_0001, 1);
    add(O, I, O, 32'h0, 32'hA0A0_0003, 32'h1_0008, I, I, 32'h1_0004, 32'hA0A0_0002, 1);
    add(O, O, O, 32'h0, 32'hA0A0_0004, 32'h1_000C, I, I, 32'h1_0008, 32'hA0A0_0003, 1);
    add(O, O, O, 32'h0, 32'hA0A0_0005, 32'h1_0010, I, I, 32'h1_0008, 32'hA0A0_0003, 2);
    add(O, O, O, 32'h0, 32'hA0A0_0006, 32'h1_0014, I, I, 32'h1_0008, 32'hA0A0_0003, 3);
    add(O, O, O, 32'h0, 32'hDEAD_0000, 32'h1_0018, O, I, 32'h1_0008, 32'hA0A0_0003, 4);
    add(O, I, O, 32'h0, 32'hDEAD_0001, 32'h1_0018, O, I, 32'h1_0008, 32'hA0A0_0003, 4);
    add(O, O, O, 32'h0, 32'hA0A0_0007, 32'h1_0018, I, I, 32'h1_000C, 32'hA0A0_0004, 3);
    add(I, I, O, 32'h0, 32'hDEAD_0002, 32'h1_001C, O, I, 32'h1_000C, 32'hA0A0_0004, 4);
    add(I, I, O, 32'h0, 32'hDEAD_0003, 32'h1_001C, I, I, 32'h1_0010, 32'hA0A0_0005, 3);
    add(I, I, O, 32'h0, 32'hDEAD_0004, 32'h1_001C, I, I, 32'h1_0014, 32'hA0A0_0006, 2);
    add(I, O, O, 32'h0, 32'hDEAD_0005, 32'h1_001C, I, I, 32'h1_0018, 32'hA0A0_0007, 1);
    add(O, O, O, 32'h0, 32'hA0A0_0008, 32'h1_001C, I, I, 32'h1_0018, 32'hA0A0_0007, 1);
    add(O, O, O, 32'h0, 32'hA0A0_0009, 32'h1_0020, I, I, 32'h1_0018, 32'hA0A0_0007, 2);
    add(O, I, I, 32'h2_0003, 32'hBAD0_0000, 32'h1_0024, O, O, 32'h0, NOP, 3);
    add(I, I, O, 32'h0, 32'hDEAD_0006, 32'h2_0000, I, O, 32'h0, NOP, 0);
    add(O, I, O, 32'h0, 32'hA0A0_000A, 32'h2_0000, I, O, 32'h0, NOP, 0);
    add(O, I, I, 32'h3_0000, 32'hBAD0_0001, 32'h2_0004, O, O, 32'h0, NOP, 1);
    add(I, O, I, 32'h4_0001, 32'hBAD0_0002, 32'h3_0000, O, O, 32'h0, NOP, 0);
    add(O, O, O, 32'h0, 32'hA0A0_000B, 32'h4_0000, I, O, 32'h0, NOP, 0);
    add(I, O, O, 32'h0, 32'hDEAD_0007, 32'h4_0004, I, I, 32'h4_0000, 32'hA0A0_000B, 1);
    foreach (tbl[k]) begin
      drive(tbl[k].ack, tbl[k].idr, tbl[k].red, tbl[k].rpc, tbl[k].idt);
      #1 chk_all($sformatf("row%0d", k), tbl[k].iad, tbl[k].ireq, tbl[k].vld, tbl[k].pc, tbl[k].ir, tbl[k].cnt);
      @(negedge clk);
    end
    // fetch address wraps past the top of the address space
    drive(I, O, I, 32'hFFFF_FFFE, 32'h0);
    @(negedge clk);
    drive(O, O, O, 32'h0, 32'hC0DE_0001);
    #1 chk("wrap.iad_top", bus.iad, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(O, O, O, 32'h0, 32'hC0DE_0002);
    #1 chk_all("wrap", 32'h0, I, I, 32'hFFFF_FFFC, 32'hC0DE_0001, 1);
    @(negedge clk);
    drive(I, O, O, 32'h0, 32'h0);
    #1 chk_all("wrap2", 32'h4, I, I, 32'hFFFF_FFFC, 32'hC0DE_0001, 2);
    // asynchronous reset between edges while holding two entries in a wait state
    #1 reset = 1'b1;
    #1 chk_all("areset", RPC, I, O, 32'h0, NOP, 0);
    @(negedge clk);
    reset = 1'b0;
    // randomized traffic against a queue-based reference model
    m_pc = RPC;
    m_q.delete();
    for (int n = 0; n < 400; n++) begin
      drive(logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) < 6),
            logic'($urandom_range(0, 19) == 0), $urandom, $urandom);
      m_ireq = (m_q.size() < DEPTH) && !bus.redirect;
      m_vld = (m_q.size() != 0) && !bus.redirect;
      #1 chk_all("rand", m_pc, m_ireq, m_vld, m_vld ? m_q[0][63:32] : 32'h0,
                 m_vld ? m_q[0][31:0] : NOP, m_q.size());
      @(posedge clk);
      if (bus.redirect) begin
        m_q.delete();
        m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (m_vld && bus.id_ready) void'(m_q.pop_front());
        if (m_ireq && !bus.acki_n) begin
          m_q.push_back({m_pc, bus.idt});
          m_pc = m_pc + 32'd4;
        end
      end
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch unit with a small prefetch buffer. Sits directly upstream of the IF-ID pipeline register.
- Drives the instruction-memory address bus and honours the ACKI_n wait handshake.
- Tags each returned word with its PC and presents in-order {pc, ir} pairs to the decode side.
- Absorbs decode stalls and flushes itself on a jump/branch redirect coming back from the later stages.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0001_0000: first fetch address after reset.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- iad, output, 32: instruction address (IAD); always equals fetch_pc.
- ireq, output, 1: fetch request this cycle.
- idt, input, 32: instruction data (IDT); valid in a cycle where ireq=1 and acki_n=0.
- acki_n, input, 1: 0 = memory ready / data valid this cycle; 1 = wait.
- redirect, input, 1: jump/branch taken; flush and refetch.
- redirect_pc, input, 32: new fetch address when redirect=1.
- id_ready, input, 1: decode accepts the head entry this cycle.
- valid_out, output, 1: head entry valid.
- ir_out, output, 32: head instruction, or 32'h0000_0013 (NOP) when not valid.
- pc_out, output, 32: head PC, or 32'h0 when not valid.
- count, output, $clog2(DEPTH)+1: current occupancy.

Behaviour:
- Reset (async, any time including mid-transfer):
  - fetch_pc=RESET_PC; head/tail pointers=0; count=0.
  - valid_out=0, ir_out=NOP, pc_out=0, ireq=1 when reset deasserts (unless redirect).
  - Any in-flight fetch is dropped.
- State:
  - fetch_pc (32b).
  - DEPTH-entry storage of {pc, ir}.
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- ireq = (count < DEPTH) && !redirect. Purely combinational. No full-queue bypass: when full, ireq=0 even if a dequeue happens that cycle.
- Enqueue when ireq && !acki_n at a clock edge:
  - write {fetch_pc, idt} at tail; tail+1; fetch_pc += 4.
  - fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Wait state: ireq && acki_n means no enqueue. fetch_pc, and therefore iad, stays stable until acki_n=0 or redirect.
- Dequeue when valid_out && id_ready && !redirect: head+1.
- valid_out = (count != 0) && !redirect.
- Latency: a word accepted at edge N appears on valid_out/ir_out/pc_out after edge N (one-cycle fetch-to-decode latency).
- Count update:
  - enqueue only: count+1.
  - dequeue only: count-1.
  - both in the same cycle: unchanged; legal whenever count is 1..DEPTH-1.
  - enqueue with count=0 and id_ready=1: the entry is not dequeued in the same cycle; no fall-through.
- Redirect has highest priority:
  - at the edge: count=0, head=tail=0, fetch_pc={redirect_pc[31:2], 2'b00}.
  - no enqueue and no dequeue that cycle; idt is ignored even if acki_n=0.
  - redirect_pc[1:0] is ignored.
  - Redirect held for several cycles keeps reloading fetch_pc and keeps ireq=0.
  - First post-redirect word can enqueue on the cycle after redirect drops.
- Ordering: entries are dequeued strictly in fetch order; PCs of consecutive entries differ by 4 unless separated by a redirect.
- No X on any output at any time after reset.

Test Plan:
- Reset then acki_n=0, id_ready=1, idt=A,B,C on consecutive cycles:
  - iad = 0x10000, 0x10004, 0x10008.
  - valid_out rises one cycle after the first enqueue; pc_out/ir_out = (0x10000,A), (0x10004,B), (0x10008,C).
- id_ready=0, acki_n=0 for 6 cycles, DEPTH=4:
  - count reaches 4, ireq=0, iad frozen at 0x10010.
  - Pulse id_ready for one cycle: count=3; next cycle ireq=1 and enqueue of 0x10010.
- acki_n=1 for 3 cycles mid-stream at iad=0x10008:
  - iad stays 0x10008, count unchanged by fetch.
  - Drop acki_n: word enqueued with pc 0x10008.
- Queue holding 3 entries; redirect=1, redirect_pc=0x20003, with acki_n=0 that same cycle:
  - next cycle count=0, valid_out=0, ir_out=0x00000013, iad=0x20000.
  - The word presented during redirect is not enqueued.
- fetch_pc at 0xFFFFFFFC, acki_n=0: entry pc_out=0xFFFFFFFC; next iad=0x00000000.
- Assert reset asynchronously between edges while count=2 and acki_n=1:
  - immediately valid_out=0, count=0, iad=0x10000, pc_out=0.
